// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the sort-RAM port arbiter.
// Optional round-robin policy is selected with RAM_ARB_RR_EN.
package ram_arb_pkg;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned REQ_SORT = 0;
  localparam int unsigned REQ_HOST = 1;

  localparam int unsigned RAM_AW = 8;
  localparam int unsigned RAM_DW = 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [RAM_AW-1:0] addr;
    logic [RAM_DW-1:0] wdata;
  } ram_cmd_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection for the two-requester RAM arbiter.
// RAM_ARB_RR_EN: ties are broken by the round-robin pointer, else the host wins.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
`ifdef RAM_ARB_RR_EN
  input  logic               i_ptr,
`endif
  input  arb_state_e         i_state,
  input  logic               i_owner,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_state == LOCKED) begin
      // The non-owner waits for the whole locked sequence, even if the owner idles.
      if (i_req[i_owner]) begin
        o_gnt = idx_to_onehot(i_owner);
      end
    end else begin
      unique case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
`ifdef RAM_ARB_RR_EN
        2'b11:   o_gnt = idx_to_onehot(i_ptr);
`else
        2'b11:   o_gnt = idx_to_onehot(1'(REQ_HOST));
`endif
        default: o_gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port sort RAM between the sort datapath (0) and the host port (1).
// RAM_ARB_RR_EN selects round-robin arbitration; otherwise the host has fixed priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned SIZE_ADDR = RAM_AW,
  parameter int unsigned SIZE_DATA = RAM_DW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic                 i_we0,
  input  logic                 i_we1,
  input  logic                 i_lock0,
  input  logic                 i_lock1,
  input  logic [SIZE_ADDR-1:0] i_addr0,
  input  logic [SIZE_ADDR-1:0] i_addr1,
  input  logic [SIZE_DATA-1:0] i_wdata0,
  input  logic [SIZE_DATA-1:0] i_wdata1,
  output logic                 o_gnt0,
  output logic                 o_gnt1,
  output logic                 o_rvalid0,
  output logic                 o_rvalid1,
  output logic [SIZE_DATA-1:0] o_rdata0,
  output logic [SIZE_DATA-1:0] o_rdata1,
  output logic                 o_ram_rd_en,
  output logic                 o_ram_wr_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_ram_wdata,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic                 o_locked,
  output logic                 o_owner
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;

  logic       cmd_vld_q, cmd_vld_d;
  ram_cmd_t   cmd_q, cmd_d;

  logic       rd_tag_q, rd_tag_d;
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;
  logic [SIZE_DATA-1:0] rdata0_q, rdata0_d;
  logic [SIZE_DATA-1:0] rdata1_q, rdata1_d;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt_raw;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               gnt_idx;
  logic               gnt_we;
  logic               gnt_lock;
  logic [SIZE_ADDR-1:0] gnt_addr;
  logic [SIZE_DATA-1:0] gnt_wdata;

`ifdef RAM_ARB_RR_EN
  logic ptr_q, ptr_d;
`endif

  assign req = {i_req1, i_req0};

  ram_arb_pick u_pick (
    .i_req   (req),
`ifdef RAM_ARB_RR_EN
    .i_ptr   (ptr_q),
`endif
    .i_state (state_q),
    .i_owner (owner_q),
    .o_gnt   (gnt_raw)
  );

  // Grants are suppressed in the reset cycle so nothing is accepted and then dropped.
  always_comb begin
    gnt       = i_rst ? '0 : gnt_raw;
    gnt_any   = |gnt;
    gnt_idx   = gnt[REQ_HOST];
    gnt_we    = gnt_idx ? i_we1    : i_we0;
    gnt_lock  = gnt_idx ? i_lock1  : i_lock0;
    gnt_addr  = gnt_idx ? i_addr1  : i_addr0;
    gnt_wdata = gnt_idx ? i_wdata1 : i_wdata0;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = gnt_any ? gnt_idx : owner_q;
    unique case (state_q)
      IDLE:    if (gnt_any && gnt_lock)  state_d = LOCKED;
      LOCKED:  if (gnt_any && !gnt_lock) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef RAM_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any && (state_q == IDLE)) begin
      ptr_d = ~gnt_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= 1'(REQ_SORT);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Command stage and read-return tag pipeline
  always_comb begin
    cmd_vld_d = gnt_any;
    cmd_d     = cmd_q;
    rd_tag_d  = rd_tag_q;
    if (gnt_any) begin
      cmd_d.we    = gnt_we;
      cmd_d.addr  = gnt_addr;
      cmd_d.wdata = gnt_wdata;
      rd_tag_d    = gnt_idx;
    end
    rvalid0_d = cmd_vld_q && !cmd_q.we && !rd_tag_q;
    rvalid1_d = cmd_vld_q && !cmd_q.we &&  rd_tag_q;
    rdata0_d  = rvalid0_q ? i_ram_rdata : rdata0_q;
    rdata1_d  = rvalid1_q ? i_ram_rdata : rdata1_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_vld_q <= 1'b0;
      cmd_q     <= '0;
      rd_tag_q  <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      cmd_vld_q <= cmd_vld_d;
      cmd_q     <= cmd_d;
      rd_tag_q  <= rd_tag_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Outputs; read data is passed straight through in its valid cycle, held otherwise.
  always_comb begin
    o_gnt0      = gnt[REQ_SORT];
    o_gnt1      = gnt[REQ_HOST];
    o_locked    = (state_q == LOCKED);
    o_owner     = owner_q;
    o_ram_rd_en = cmd_vld_q && !cmd_q.we;
    o_ram_wr_en = cmd_vld_q &&  cmd_q.we;
    o_ram_addr  = cmd_q.addr;
    o_ram_wdata = cmd_q.wdata;
    o_rvalid0   = rvalid0_q;
    o_rvalid1   = rvalid1_q;
    o_rdata0    = rvalid0_q ? i_ram_rdata : rdata0_q;
    o_rdata1    = rvalid1_q ? i_ram_rdata : rdata1_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a cycle-scheduled reference model and a RAM model.
// Honours RAM_ARB_RR_EN the same way as the design.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_req0 = 1'b0, i_req1 = 1'b0;
  logic       i_we0 = 1'b0, i_we1 = 1'b0;
  logic       i_lock0 = 1'b0, i_lock1 = 1'b0;
  logic [7:0] i_addr0 = '0, i_addr1 = '0;
  logic [7:0] i_wdata0 = '0, i_wdata1 = '0;
  logic       o_gnt0, o_gnt1, o_rvalid0, o_rvalid1;
  logic [7:0] o_rdata0, o_rdata1;
  logic       o_ram_rd_en, o_ram_wr_en;
  logic [7:0] o_ram_addr, o_ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic       o_locked, o_owner;

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(
    .SIZE_ADDR (8),
    .SIZE_DATA (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req0      (i_req0),
    .i_req1      (i_req1),
    .i_we0       (i_we0),
    .i_we1       (i_we1),
    .i_lock0     (i_lock0),
    .i_lock1     (i_lock1),
    .i_addr0     (i_addr0),
    .i_addr1     (i_addr1),
    .i_wdata0    (i_wdata0),
    .i_wdata1    (i_wdata1),
    .o_gnt0      (o_gnt0),
    .o_gnt1      (o_gnt1),
    .o_rvalid0   (o_rvalid0),
    .o_rvalid1   (o_rvalid1),
    .o_rdata0    (o_rdata0),
    .o_rdata1    (o_rdata1),
    .o_ram_rd_en (o_ram_rd_en),
    .o_ram_wr_en (o_ram_wr_en),
    .o_ram_addr  (o_ram_addr),
    .o_ram_wdata (o_ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_locked    (o_locked),
    .o_owner     (o_owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h05) ? 8'h3C : a + 8'h40;
  endfunction

  // Registered-read single-port RAM, preloaded on the first edge.
  logic [7:0] mem [256];
  bit         mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      mem_init <= 1'b1;
    end else begin
      if (o_ram_rd_en) ram_rdata <= mem[o_ram_addr];
      if (o_ram_wr_en) mem[o_ram_addr] <= o_ram_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grants decided by the arbitration rules; each grant schedules a
  // RAM command one cycle later and, for reads, a return two cycles later.
  typedef struct packed {
    logic       we;
    logic       tag;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_cmd_t;
  typedef struct packed {
    logic       tag;
    logic [7:0] data;
  } exp_rv_t;

  exp_cmd_t   sch_cmd [int];
  exp_rv_t    sch_rv  [int];
  logic [7:0] shadow  [256];
  logic       m_locked = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
  logic [7:0] m_addr = '0, m_wdata = '0, m_rd0 = '0, m_rd1 = '0;

  initial begin : model
    int         cyc;
    exp_cmd_t   c;
    exp_rv_t    r;
    logic [1:0] req, e_g;
    logic       e_rd, e_wr, e_rv0, e_rv1, g_idx, g_we, g_lock;
    cyc = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    forever begin
      @(negedge clk);
      e_rd = 1'b0; e_wr = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
      if (sch_cmd.exists(cyc)) begin
        c = sch_cmd[cyc];
        sch_cmd.delete(cyc);
        e_rd = !c.we; e_wr = c.we;
        m_addr = c.addr; m_wdata = c.wdata;
        if (c.we) shadow[c.addr] = c.wdata;
        else      sch_rv[cyc+1] = '{c.tag, shadow[c.addr]};
      end
      if (sch_rv.exists(cyc)) begin
        r = sch_rv[cyc];
        sch_rv.delete(cyc);
        if (r.tag) begin e_rv1 = 1'b1; m_rd1 = r.data; end
        else       begin e_rv0 = 1'b1; m_rd0 = r.data; end
      end
      req = {i_req1, i_req0};
      e_g = 2'b00;
      if (!i_rst) begin
        if (m_locked) begin
          if (req[m_owner]) e_g[m_owner] = 1'b1;
        end else if (req == 2'b11) begin
`ifdef RAM_ARB_RR_EN
          e_g[m_ptr] = 1'b1;
`else
          e_g[1] = 1'b1;
`endif
        end else begin
          e_g = req;
        end
      end
      chk("gnt0", o_gnt0, e_g[0]);
      chk("gnt1", o_gnt1, e_g[1]);
      chk("ram_rd_en", o_ram_rd_en, e_rd);
      chk("ram_wr_en", o_ram_wr_en, e_wr);
      chk("ram_addr", o_ram_addr, m_addr);
      if (e_wr) chk("ram_wdata", o_ram_wdata, m_wdata);
      chk("rvalid0", o_rvalid0, e_rv0);
      chk("rvalid1", o_rvalid1, e_rv1);
      chk("rdata0", o_rdata0, m_rd0);
      chk("rdata1", o_rdata1, m_rd1);
      chk("locked", o_locked, m_locked);
      chk("owner", o_owner, m_owner);
      if (e_g != 2'b00) begin
        g_idx  = e_g[1];
        g_we   = g_idx ? i_we1 : i_we0;
        g_lock = g_idx ? i_lock1 : i_lock0;
        sch_cmd[cyc+1] = '{g_we, g_idx, (g_idx ? i_addr1 : i_addr0),
                           (g_idx ? i_wdata1 : i_wdata0)};
        if (!m_locked) begin
          m_ptr = ~g_idx;
          if (g_lock) m_locked = 1'b1;
        end else if (!g_lock) begin
          m_locked = 1'b0;
        end
        m_owner = g_idx;
      end
      if (i_rst) begin
        if (sch_cmd.exists(cyc+1)) sch_cmd.delete(cyc+1);
        if (sch_rv.exists(cyc+1))  sch_rv.delete(cyc+1);
        m_locked = 1'b0; m_owner = 1'b0; m_ptr = 1'b0;
        m_addr = '0; m_wdata = '0; m_rd0 = '0; m_rd1 = '0;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic req, input logic we, input logic lock,
                      input logic [7:0] addr, input logic [7:0] wdata);
    i_req0 = req; i_we0 = we; i_lock0 = lock; i_addr0 = addr; i_wdata0 = wdata;
  endtask

  task automatic set1(input logic req, input logic we, input logic lock,
                      input logic [7:0] addr, input logic [7:0] wdata);
    i_req1 = req; i_we1 = we; i_lock1 = lock; i_addr1 = addr; i_wdata1 = wdata;
  endtask

  initial begin : stim
    logic [3:0] win;
    logic [3:0] win_exp;
`ifdef RAM_ARB_RR_EN
    win_exp = 4'b1010;
`else
    win_exp = 4'b1111;
`endif
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt", {30'd0, o_gnt1, o_gnt0}, 32'd0);
    chk("rst_ram", {o_ram_rd_en, o_ram_wr_en, o_ram_addr, o_ram_wdata}, 32'd0);
    chk("rst_misc", {o_locked, o_owner, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1}, 32'd0);
    tick(); i_rst = 1'b0;

    // Single read, no contention
    tick(); set0(1, 0, 0, 8'h05, 8'h00);
    @(negedge clk); chk("sr_gnt0", o_gnt0, 1'b1);
    tick(); set0(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk); chk("sr_rd_en", o_ram_rd_en, 1'b1); chk("sr_addr", o_ram_addr, 8'h05);
    tick();
    @(negedge clk);
    chk("sr_rvalid0", o_rvalid0, 1'b1); chk("sr_rdata0", o_rdata0, 8'h3C);
    chk("sr_rvalid1", o_rvalid1, 1'b0);

    // Write then read the same address
    tick(); set1(1, 1, 0, 8'h10, 8'h5A);
    @(negedge clk); chk("wr_gnt1", o_gnt1, 1'b1);
    tick(); set1(1, 0, 0, 8'h10, 8'h00);
    @(negedge clk); chk("wr_en", o_ram_wr_en, 1'b1); chk("wr_wdata", o_ram_wdata, 8'h5A);
    tick(); set1(0, 0, 0, 8'h00, 8'h00);
    tick();
    @(negedge clk); chk("wr_rvalid1", o_rvalid1, 1'b1); chk("wr_rdata1", o_rdata1, 8'h5A);

    // Pipelined host reads of 0x00..0x02
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i < 3) set1(1, 0, 0, 8'(i), 8'h00);
      else       set1(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      if (i < 3) chk("pl_gnt1", o_gnt1, 1'b1);
      if (i >= 2) begin
        chk("pl_rvalid1", o_rvalid1, 1'b1);
        chk("pl_rdata1", o_rdata1, 8'h40 + 8'(i - 2));
      end
    end

    // Contention: both requesters held high for four cycles
    win = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      set0(1, 0, 0, 8'h30, 8'h00);
      set1(1, 0, 0, 8'h31, 8'h00);
      @(negedge clk);
      chk("ct_onehot", {31'd0, o_gnt0 ^ o_gnt1}, 32'd1);
      win[i] = o_gnt1;
    end
    chk("ct_order", win, win_exp);
    tick(); set0(0, 0, 0, 8'h00, 8'h00); set1(0, 0, 0, 8'h00, 8'h00);
    tick(); tick();

    // Locked swap by the sort datapath while the host waits
    tick(); set0(1, 0, 1, 8'h02, 8'h00);
    @(negedge clk); chk("lk_gnt0_a", o_gnt0, 1'b1);
    tick(); set0(1, 0, 1, 8'h07, 8'h00); set1(1, 0, 0, 8'h20, 8'h00);
    @(negedge clk); chk("lk_gnt0_b", o_gnt0, 1'b1); chk("lk_hold_b", o_gnt1, 1'b0);
    chk("lk_locked_b", o_locked, 1'b1);
    tick(); set0(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk); chk("lk_gap_gnt1", o_gnt1, 1'b0); chk("lk_locked_gap", o_locked, 1'b1);
    tick(); set0(1, 1, 1, 8'h02, 8'hAA);
    @(negedge clk); chk("lk_gnt0_c", o_gnt0, 1'b1); chk("lk_hold_c", o_gnt1, 1'b0);
    tick(); set0(1, 1, 0, 8'h07, 8'h11);
    @(negedge clk); chk("lk_gnt0_d", o_gnt0, 1'b1); chk("lk_hold_d", o_gnt1, 1'b0);
    chk("lk_locked_d", o_locked, 1'b1);
    tick(); set0(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk); chk("lk_rel_gnt1", o_gnt1, 1'b1); chk("lk_rel_locked", o_locked, 1'b0);
    tick(); set1(0, 0, 0, 8'h00, 8'h00);
    tick(); tick();
    @(negedge clk); chk("lk_mem2", mem[2], 8'hAA); chk("lk_mem7", mem[7], 8'h11);

    // Reset while locked with a read in flight
    tick(); set0(1, 0, 1, 8'h03, 8'h00);
    @(negedge clk); chk("rl_gnt0", o_gnt0, 1'b1);
    tick(); set0(0, 0, 0, 8'h00, 8'h00); i_rst = 1'b1;
    @(negedge clk); chk("rl_rd_en", o_ram_rd_en, 1'b1); chk("rl_locked", o_locked, 1'b1);
    tick(); i_rst = 1'b0; set1(1, 0, 0, 8'h04, 8'h00);
    @(negedge clk);
    chk("rl_gnt1", o_gnt1, 1'b1); chk("rl_rvalid0", o_rvalid0, 1'b0);
    chk("rl_outs", {o_locked, o_owner, o_ram_rd_en, o_ram_wr_en, o_ram_addr, o_rdata0}, 32'd0);
    tick(); set1(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk); chk("rl_rvalid0_b", o_rvalid0, 1'b0);
    tick();
    @(negedge clk); chk("rl_rvalid1", o_rvalid1, 1'b1); chk("rl_rdata1", o_rdata1, 8'h44);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
